msrv32_wb_stage_unit: RTL and testbench

Registered, parametrised writeback stage for the msrv32 core. It accepts one instruction per handshake from execute and selects the writeback source. It holds the stage while a load result is outstanding, then drives a single registered register-file write port. It also keeps the 64-bit retired-instruction counter and drives the ALU second-operand mux (rs2 or immediate).

---
 rtl/msrv32_pkg.sv | 20 ++
 rtl/msrv32_wb_src_mux.sv | 39 +++
 rtl/msrv32_wb_stage_unit.sv | 138 +++++++++++++
 tb/tb_msrv32_wb_stage_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 writeback stage: source-select codes,
// writeback FSM encodings and the default datapath width.
package msrv32_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Writeback source-select codes; 6 and 7 fall back to the ALU result.
  localparam logic [2:0] WB_ALU     = 3'd0;
  localparam logic [2:0] WB_LU      = 3'd1;
  localparam logic [2:0] WB_IMM     = 3'd2;
  localparam logic [2:0] WB_IADDER  = 3'd3;
  localparam logic [2:0] WB_CSR     = 3'd4;
  localparam logic [2:0] WB_PC_PLUS = 3'd5;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/msrv32_wb_src_mux.sv
// Combinational writeback source select plus the ALU second-operand mux.
module msrv32_wb_src_mux
  import msrv32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] wb_mux_sel_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  lu_output_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [XLEN-1:0]  iadder_out_in,
  input  logic [XLEN-1:0]  csr_data_in,
  input  logic [XLEN-1:0]  pc_plus_4_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic             alu_source_in,
  output logic [XLEN-1:0]  wb_mux_out,
  output logic [XLEN-1:0]  alu_2nd_src_mux_out
);

  // Pick the writeback source; unused codes write the ALU result.
  always_comb begin
    wb_mux_out = alu_result_in;
    case (wb_mux_sel_in)
      SEL_W'(WB_LU):      wb_mux_out = lu_output_in;
      SEL_W'(WB_IMM):     wb_mux_out = imm_in;
      SEL_W'(WB_IADDER):  wb_mux_out = iadder_out_in;
      SEL_W'(WB_CSR):     wb_mux_out = csr_data_in;
      SEL_W'(WB_PC_PLUS): wb_mux_out = pc_plus_4_in;
      default:            wb_mux_out = alu_result_in;
    endcase
  end

  // Second ALU operand: rs2 when alu_source_in is set, immediate otherwise.
  always_comb begin
    alu_2nd_src_mux_out = alu_source_in ? rs2_in : imm_in;
  end

endmodule

// File: rtl/msrv32_wb_stage_unit.sv
// Registered writeback stage: accepts one instruction per handshake, waits
// for load data when needed, drives one registered register-file write port
// and keeps the retired-instruction counter.
//
// Handshake: an instruction transfers on a cycle where wb_valid_in and
// wb_ready_out are both high and flush_in is low. wb_ready_out depends only
// on the FSM state, never on wb_valid_in. A flushed offer is simply dropped.
module msrv32_wb_stage_unit
  import msrv32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int SEL_W = 3,
  parameter int CNT_W = 64
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             wb_valid_in,
  output logic             wb_ready_out,
  input  logic [SEL_W-1:0] wb_mux_sel_in,
  input  logic [4:0]       rd_addr_in,
  input  logic             alu_source_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [XLEN-1:0]  iadder_out_in,
  input  logic [XLEN-1:0]  csr_data_in,
  input  logic [XLEN-1:0]  pc_plus_4_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic [XLEN-1:0]  lu_output_in,
  input  logic             lu_valid_in,
  input  logic             flush_in,
  input  logic             instret_inhibit_in,
  output logic [XLEN-1:0]  alu_2nd_src_mux_out,
  output logic             rf_wr_en_out,
  output logic [4:0]       rf_rd_addr_out,
  output logic [XLEN-1:0]  rf_wr_data_out,
  output logic             retire_out,
  output logic [CNT_W-1:0] instret_out,
  output logic             load_pending_out,
  output wb_state_e        wb_state_dbg_out
);

  wb_state_e        state_q, state_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]  wr_data_q, wr_data_d;
  logic             wr_en_q;
  logic             retire_q;
  logic [CNT_W-1:0] instret_q;
  logic [XLEN-1:0]  wb_src_data;
  logic             accept;
  logic             do_retire;

  msrv32_wb_src_mux #(
    .XLEN  (XLEN),
    .SEL_W (SEL_W)
  ) u_src_mux (
    .wb_mux_sel_in       (wb_mux_sel_in),
    .alu_result_in       (alu_result_in),
    .lu_output_in        (lu_output_in),
    .imm_in              (imm_in),
    .iadder_out_in       (iadder_out_in),
    .csr_data_in         (csr_data_in),
    .pc_plus_4_in        (pc_plus_4_in),
    .rs2_in              (rs2_in),
    .alu_source_in       (alu_source_in),
    .wb_mux_out          (wb_src_data),
    .alu_2nd_src_mux_out (alu_2nd_src_mux_out)
  );

  // Next state and the write/retire decision for this cycle.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    do_retire = 1'b0;
    accept    = wb_valid_in & (state_q == WB_IDLE) & ~flush_in;
    case (state_q)
      WB_IDLE: begin
        if (accept) begin
          if (wb_mux_sel_in == SEL_W'(WB_LU)) begin
            // Load: remember rd and wait for the load unit.
            state_d   = WB_LOAD_WAIT;
            pend_rd_d = rd_addr_in;
          end else begin
            do_retire = 1'b1;
            wr_addr_d = rd_addr_in;
            wr_data_d = wb_src_data;
          end
        end
      end
      WB_LOAD_WAIT: begin
        // Flush beats a simultaneous load-data valid.
        if (flush_in) begin
          state_d = WB_IDLE;
        end else if (lu_valid_in) begin
          state_d   = WB_IDLE;
          do_retire = 1'b1;
          wr_addr_d = pend_rd_q;
          wr_data_d = lu_output_in;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // State, write port and retire counter registers.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q   <= WB_IDLE;
      pend_rd_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      retire_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      // x0 is hardwired: retire it but never strobe the write.
      wr_en_q   <= do_retire & (wr_addr_d != 5'd0);
      retire_q  <= do_retire;
      instret_q <= instret_q + CNT_W'(do_retire & ~instret_inhibit_in);
    end
  end

  assign wb_ready_out     = (state_q == WB_IDLE);
  assign load_pending_out = (state_q == WB_LOAD_WAIT);
  assign wb_state_dbg_out = state_q;
  assign rf_wr_en_out     = wr_en_q;
  assign rf_rd_addr_out   = wr_addr_q;
  assign rf_wr_data_out   = wr_data_q;
  assign retire_out       = retire_q;
  assign instret_out      = instret_q;

endmodule

// File: tb/tb_msrv32_wb_stage_unit.sv
// Self-checking bench for msrv32_wb_stage_unit: directed stimulus, a retire
// scoreboard checked every falling edge, and literal spot checks.
module tb_msrv32_wb_stage_unit
  import msrv32_pkg::*;
;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  sel;
  logic [4:0]  rd;
  logic        alu_src;
  logic [31:0] alu_res, imm, iadder, csr, pc4, rs2, lu_out;
  logic        lu_valid, flush, inhibit;
  logic [31:0] mux_out;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        retire;
  logic [63:0] instret;
  logic        load_pending;
  wb_state_e   dbg_state;

  msrv32_wb_stage_unit dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .wb_valid_in          (wb_valid),
    .wb_ready_out         (wb_ready),
    .wb_mux_sel_in        (sel),
    .rd_addr_in           (rd),
    .alu_source_in        (alu_src),
    .alu_result_in        (alu_res),
    .imm_in               (imm),
    .iadder_out_in        (iadder),
    .csr_data_in          (csr),
    .pc_plus_4_in         (pc4),
    .rs2_in               (rs2),
    .lu_output_in         (lu_out),
    .lu_valid_in          (lu_valid),
    .flush_in             (flush),
    .instret_inhibit_in   (inhibit),
    .alu_2nd_src_mux_out  (mux_out),
    .rf_wr_en_out         (wr_en),
    .rf_rd_addr_out       (wr_addr),
    .rf_wr_data_out       (wr_data),
    .retire_out           (retire),
    .instret_out          (instret),
    .load_pending_out     (load_pending),
    .wb_state_dbg_out     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [63:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_cnt;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic [63:0] last_cnt;
  logic        skip_cnt;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d, input logic inh);
    exp_t e;
    if (!inh) exp_cnt = exp_cnt + 64'd1;
    e.cyc  = 32'(cyc + 1);
    e.we   = (a != 5'd0);
    e.addr = a;
    e.data = d;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_sources();
    alu_res = 32'hA1A1_0000;
    imm     = 32'hB2B2_0000;
    iadder  = 32'hC3C3_0000;
    csr     = 32'hD4D4_0000;
    pc4     = 32'hE5E5_0000;
    lu_out  = 32'hF6F6_0000;
  endtask

  // Offer one non-load instruction for a single cycle.
  task automatic send(input logic [2:0] s, input logic [4:0] r, input logic [31:0] v,
                      input logic inh);
    set_sources();
    case (s)
      3'd2:    imm     = v;
      3'd3:    iadder  = v;
      3'd4:    csr     = v;
      3'd5:    pc4     = v;
      default: alu_res = v;
    endcase
    wb_valid = 1'b1;
    sel      = s;
    rd       = r;
    inhibit  = inh;
    push_exp(r, v, inh);
    step();
    wb_valid = 1'b0;
    inhibit  = 1'b0;
  endtask

  // Load: accept, wait nwait cycles, then present lu_valid (optionally with flush).
  task automatic load(input logic [4:0] r, input int nwait, input logic [31:0] d,
                      input logic fl, input logic inh, input logic lu_in_accept);
    set_sources();
    wb_valid = 1'b1;
    sel      = 3'd1;
    rd       = r;
    lu_valid = lu_in_accept;
    lu_out   = 32'h0BAD_0BAD;
    step();
    wb_valid = 1'b0;
    lu_valid = 1'b0;
    check("load_ready_low", wb_ready, 0);
    check("load_pending_high", load_pending, 1);
    check("load_dbg_state", dbg_state, WB_LOAD_WAIT);
    for (int i = 0; i < nwait; i++) begin
      step();
      check("load_wait_ready_low", wb_ready, 0);
    end
    lu_valid = 1'b1;
    lu_out   = d;
    flush    = fl;
    inhibit  = inh;
    if (!fl) push_exp(r, d, inh);
    step();
    lu_valid = 1'b0;
    flush    = 1'b0;
    inhibit  = 1'b0;
    check("load_done_ready", wb_ready, 1);
    check("load_done_pending", load_pending, 0);
  endtask

  // ---------------- compare process body ----------------
  task automatic compare_cycle();
    exp_t e;
    if (!rst_n) begin
      check("rst_wr_en", wr_en, 0);
      check("rst_retire", retire, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_data", wr_data, 0);
      check("rst_instret", instret, 0);
      check("rst_ready", wb_ready, 1);
      exp_q.delete();
      last_addr = '0;
      last_data = '0;
      last_cnt  = '0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc < 32'(cyc)) begin
        check("retire_missing_cycle", 64'(cyc), 64'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("sb_retire", retire, 1);
        check("sb_wr_en", wr_en, e.we);
        check("sb_addr", wr_addr, e.addr);
        check("sb_data", wr_data, e.data);
        if (!skip_cnt) check("sb_instret", instret, e.cnt);
        last_addr = e.addr;
        last_data = e.data;
        last_cnt  = e.cnt;
      end else begin
        check("idle_retire", retire, 0);
        check("idle_wr_en", wr_en, 0);
        check("hold_addr", wr_addr, last_addr);
        check("hold_data", wr_data, last_data);
        if (!skip_cnt) check("hold_instret", instret, last_cnt);
      end
    end
  endtask

  // ---------------- stimulus, compare and report ----------------
  initial begin
    checks = 0; errors = 0;
    exp_cnt = '0; last_addr = '0; last_data = '0; last_cnt = '0; skip_cnt = 1'b0;
    wb_valid = 1'b0; sel = 3'd0; rd = 5'd0; alu_src = 1'b0; rs2 = '0;
    lu_valid = 1'b0; flush = 1'b0; inhibit = 1'b0;
    set_sources();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    fork
      begin : stimulus
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // ALU writeback, literal pins on the first retire.
        send(3'd0, 5'd5, 32'h0000_1234, 1'b0);
        check("lit_wr_en", wr_en, 1);
        check("lit_addr", wr_addr, 5);
        check("lit_data", wr_data, 32'h1234);
        check("lit_retire", retire, 1);
        check("lit_instret", instret, 1);
        step();
        check("lit_wr_en_drop", wr_en, 0);

        // Load with two wait cycles; lu_valid in the accept cycle is ignored.
        load(5'd7, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        check("lit_load_addr", wr_addr, 7);
        check("lit_load_data", wr_data, 32'hDEADBEEF);
        check("lit_load_instret", instret, 2);
        step();

        // Flush together with lu_valid: no write, no count.
        load(5'd8, 1, 32'h8888_8888, 1'b1, 1'b0, 1'b0);
        step();

        // Flush in IDLE blocks the accept.
        set_sources();
        wb_valid = 1'b1; sel = 3'd0; rd = 5'd9; flush = 1'b1;
        step();
        wb_valid = 1'b0; flush = 1'b0;
        check("flush_idle_ready", wb_ready, 1);
        step();

        // Back-to-back sources, then default codes 6 and 7.
        send(3'd2, 5'd10, 32'h1000_0002, 1'b0);
        send(3'd3, 5'd11, 32'h1000_0003, 1'b0);
        send(3'd4, 5'd12, 32'h1000_0004, 1'b0);
        send(3'd5, 5'd13, 32'h1000_0005, 1'b0);
        send(3'd6, 5'd14, 32'h1000_0006, 1'b0);
        send(3'd7, 5'd15, 32'h1000_0007, 1'b0);
        step();

        // Fastest load completion, with inhibit in the capture cycle.
        load(5'd9, 0, 32'h0000_0099, 1'b0, 1'b1, 1'b0);

        // rd = 0 and instret inhibit.
        send(3'd0, 5'd0, 32'h5555_5555, 1'b0);
        check("lit_rd0_wr_en", wr_en, 0);
        check("lit_rd0_retire", retire, 1);
        send(3'd0, 5'd0, 32'h6666_6666, 1'b1);
        send(3'd0, 5'd3, 32'h7777_7777, 1'b1);
        step();

        // Counter wrap from all-ones.
        skip_cnt = 1'b1;
        force dut.instret_q = '1;
        #1 release dut.instret_q;
        exp_cnt = '1;
        send(3'd0, 5'd4, 32'h4444_4444, 1'b0);
        skip_cnt = 1'b0;
        check("lit_wrap_instret", instret, 0);
        step();

        // Asynchronous reset while waiting for a load.
        send(3'd0, 5'd6, 32'hCAFE_F00D, 1'b0);
        set_sources();
        wb_valid = 1'b1; sel = 3'd1; rd = 5'd20;
        step();
        wb_valid = 1'b0;
        check("pre_rst_pending", load_pending, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_data", wr_data, 0);
        check("async_rst_addr", wr_addr, 0);
        check("async_rst_instret", instret, 0);
        check("async_rst_ready", wb_ready, 1);
        check("async_rst_pending", load_pending, 0);
        exp_cnt = '0;
        step();
        rst_n = 1'b1;
        lu_valid = 1'b1; lu_out = 32'h1357_9BDF;
        step();
        lu_valid = 1'b0;
        check("post_rst_ready", wb_ready, 1);
        step();

        // Second-operand mux follows alu_source combinationally.
        rs2 = 32'h1111_2222; imm = 32'h3333_4444;
        alu_src = 1'b1;
        #1 check("mux_rs2", mux_out, 32'h1111_2222);
        alu_src = 1'b0;
        #1 check("mux_imm", mux_out, 32'h3333_4444);

        repeat (3) step();
        check("queue_drained", 64'(exp_q.size()), 0);
      end
      begin : compare
        forever @(negedge clk) compare_cycle();
      end
      begin : watchdog
        #100000;
        check("timeout_cycle", 64'(cyc), 0);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
